// File: rtl/demodulator_pam_if.sv
// Link + FIFO-side signal bundle for demodulator_pam: serial link lines in,
// write strobe / received word / status out.
interface demodulator_pam_if #(
    parameter int WIDTH = 8
);
    logic             sdata;
    logic             nsync;
    logic             bclk;
    logic             full;
    logic             write;
    logic [WIDTH-1:0] sample;
    logic             overrun;
    logic             frame_err;

    modport master (
        output sdata, nsync, bclk, full,
        input  write, sample, overrun, frame_err
    );

    modport slave (
        input  sdata, nsync, bclk, full,
        output write, sample, overrun, frame_err
    );
endinterface

// File: rtl/demodulator_pam.sv
// PAM serial receiver: oversamples sdata/nsync/bclk, frames WIDTH-bit words MSB first
// and writes them to a FIFO. Define DEMOD_INPUT_SYNC_EN for 2-flop input synchronizers.
module demodulator_pam #(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 1200
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    demodulator_pam_if.slave   bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, STORE} state_t;

    logic bclk_q, nsync_q, sdata_q, bclk_d, bclk_rise;

`ifdef DEMOD_INPUT_SYNC_EN
    logic [1:0] bclk_s, nsync_s, sdata_s;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bclk_s  <= 2'b00;
            nsync_s <= 2'b11;
            sdata_s <= 2'b00;
        end else begin
            bclk_s  <= {bclk_s[0], bus.bclk};
            nsync_s <= {nsync_s[0], bus.nsync};
            sdata_s <= {sdata_s[0], bus.sdata};
        end
    end
    assign bclk_q  = bclk_s[1];
    assign nsync_q = nsync_s[1];
    assign sdata_q = sdata_s[1];
`else
    logic bclk_s, nsync_s, sdata_s;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bclk_s  <= 1'b0;
            nsync_s <= 1'b1;
            sdata_s <= 1'b0;
        end else begin
            bclk_s  <= bus.bclk;
            nsync_s <= bus.nsync;
            sdata_s <= bus.sdata;
        end
    end
    assign bclk_q  = bclk_s;
    assign nsync_q = nsync_s;
    assign sdata_q = sdata_s;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) bclk_d <= 1'b0;
        else      bclk_d <= bclk_q;
    end
    assign bclk_rise = bclk_q & ~bclk_d;

    state_t           state, state_nxt;
    logic [CW-1:0]    bcnt;
    logic [TW-1:0]    tcnt;
    logic [WIDTH-1:0] shreg;
    logic             word_done, timed_out, load, shift;
    logic             wr_nxt, err_nxt, ovr_set;
    logic             write_q, overrun_q, frame_err_q;
    logic [WIDTH-1:0] sample_q;

    assign word_done = (bcnt == CW'(WIDTH));
    assign timed_out = (tcnt == TW'(TIMEOUT));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (enable && bclk_rise && !nsync_q) state_nxt = SHIFT;
            SHIFT: begin
                if (!enable)        state_nxt = IDLE;
                else if (word_done) state_nxt = STORE;
                else if (timed_out) state_nxt = IDLE;
            end
            STORE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // A mid-word nsync=0 rise restarts the word (resync) rather than shifting.
    always_comb begin
        load    = 1'b0;
        shift   = 1'b0;
        wr_nxt  = 1'b0;
        err_nxt = 1'b0;
        ovr_set = 1'b0;
        case (state)
            IDLE:  load = enable && bclk_rise && !nsync_q;
            SHIFT: if (enable && !word_done) begin
                if (timed_out) begin
                    err_nxt = 1'b1;
                end else if (bclk_rise) begin
                    load    = !nsync_q;
                    shift   = nsync_q;
                    err_nxt = !nsync_q;
                end
            end
            STORE: if (enable) begin
                wr_nxt  = !bus.full;
                ovr_set = bus.full;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shreg <= '0;
            bcnt  <= '0;
            tcnt  <= '0;
        end else if (load) begin
            shreg <= WIDTH'(sdata_q);
            bcnt  <= CW'(1);
            tcnt  <= '0;
        end else if (shift) begin
            shreg <= {shreg[WIDTH-2:0], sdata_q};
            bcnt  <= bcnt + CW'(1);
            tcnt  <= '0;
        end else if (state == SHIFT && state_nxt == SHIFT) begin
            if (!timed_out) tcnt <= tcnt + TW'(1);
        end else begin
            bcnt <= '0;
            tcnt <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            write_q     <= 1'b0;
            sample_q    <= '0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            write_q     <= wr_nxt;
            frame_err_q <= err_nxt;
            if (wr_nxt)  sample_q  <= shreg;
            if (ovr_set) overrun_q <= 1'b1;
        end
    end

    assign bus.write     = write_q;
    assign bus.sample    = sample_q;
    assign bus.overrun   = overrun_q;
    assign bus.frame_err = frame_err_q;
endmodule

// File: tb/tb_demodulator_pam.sv
// Self-checking bench for demodulator_pam: table vectors, corner-case sequences
// and randomized frames against a word-level reference model.
module tb_demodulator_pam;
    localparam int W    = 8;
    localparam int TO   = 1200;
    localparam int HALF = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic enable = 1'b0;

    demodulator_pam_if #(.WIDTH(W)) bus ();

    demodulator_pam #(.WIDTH(W), .TIMEOUT(TO)) dut (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    int cyc = 0, fe_cnt = 0, wr_cnt = 0, fe_cyc = 0, last_rise = 0;
    int wr_cyc[$];
    logic [W-1:0] expq[$];
    logic         exp_ovr = 1'b0;
    logic [W-1:0] last_wr = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Word-level scoreboard: every write must match the oldest expected word.
    always @(posedge clk) begin
        #1;
        if (bus.write === 1'b1) begin
            wr_cnt++;
            wr_cyc.push_back(cyc);
            if (expq.size() == 0) chk("unexpected_write", 32'(bus.sample), 32'hFFFF_FFFF);
            else                  chk("sample", 32'(bus.sample), 32'(expq.pop_front()));
        end
        if (bus.frame_err === 1'b1) begin
            fe_cnt++;
            fe_cyc = cyc;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic idle(input int n);
        bus.bclk  = 1'b0;
        bus.nsync = 1'b1;
        tick(n);
    endtask

    task automatic send_bits(input logic [W-1:0] w, input int nb, input int h);
        for (int i = 0; i < nb; i++) begin
            bus.bclk  = 1'b0;
            bus.sdata = w[W-1-i];
            bus.nsync = (i == 0) ? 1'b0 : 1'b1;
            tick(h);
            bus.bclk  = 1'b1;
            last_rise = cyc;
            tick(h);
        end
    endtask

    // Full frame with FIFO state held through the store window; model updated from the rules.
    task automatic frame(input logic [W-1:0] w, input logic f, input int h);
        bus.full = f;
        if (f) exp_ovr = 1'b1;
        else begin
            expq.push_back(w);
            last_wr = w;
        end
        send_bits(w, W, h);
        idle(12);
        bus.full = 1'b0;
        chk("pending_writes", 32'(expq.size()), 32'd0);
        chk("overrun", 32'(bus.overrun), 32'(exp_ovr));
        chk("sample_hold", 32'(bus.sample), 32'(last_wr));
    endtask

    typedef struct {
        logic [W-1:0] w;
        logic         full;
        logic         ovr;
        int           writes;
    } vec_t;

    initial begin
        vec_t tbl[4];
        int fe0, wc0, dt, n;
        logic [W-1:0] rw;
        logic rf;

        tbl[0] = '{8'hAA, 1'b0, 1'b0, 1};
        tbl[1] = '{8'h55, 1'b0, 1'b0, 1};
        tbl[2] = '{8'h3C, 1'b1, 1'b1, 0};
        tbl[3] = '{8'h81, 1'b0, 1'b1, 1};

        bus.sdata = 1'b0; bus.nsync = 1'b1; bus.bclk = 1'b0; bus.full = 1'b0;
        tick(3);
        chk("rst_write",     32'(bus.write),     32'd0);
        chk("rst_sample",    32'(bus.sample),    32'd0);
        chk("rst_overrun",   32'(bus.overrun),   32'd0);
        chk("rst_frame_err", 32'(bus.frame_err), 32'd0);
        rst = 1'b1;
        enable = 1'b1;
        tick(4);

        for (int i = 0; i < 4; i++) begin
            fe0 = fe_cnt; wc0 = wr_cnt;
            frame(tbl[i].w, tbl[i].full, 4);
            chk("tbl_overrun", 32'(bus.overrun), 32'(tbl[i].ovr));
            chk("tbl_writes", 32'(wr_cnt - wc0), 32'(tbl[i].writes));
            chk("tbl_frame_err", 32'(fe_cnt - fe0), 32'd0);
        end

        // Continuous frames, loopback-style: write spacing equals the frame period.
        expq.push_back(8'hAA);
        expq.push_back(8'h55);
        last_wr = 8'h55;
        wc0 = wr_cnt;
        send_bits(8'hAA, W, HALF);
        send_bits(8'h55, W, HALF);
        idle(12);
        chk("b2b_writes", 32'(wr_cnt - wc0), 32'd2);
        n = wr_cyc.size();
        if (n >= 2) chk("b2b_spacing", 32'(wr_cyc[n-1] - wr_cyc[n-2]), 32'(2 * HALF * W));

        // Resync after 5 bits.
        fe0 = fe_cnt; wc0 = wr_cnt;
        send_bits(8'hE7, 5, HALF);
        frame(8'hF0, 1'b0, HALF);
        chk("resync_frame_err", 32'(fe_cnt - fe0), 32'd1);
        chk("resync_writes", 32'(wr_cnt - wc0), 32'd1);

        // Timeout after 3 bits.
        wc0 = wr_cnt;
        send_bits(8'hA5, 3, HALF);
        fe0 = fe_cnt;
        idle(TO + 10);
        dt = fe_cyc - last_rise;
        chk("timeout_frame_err", 32'(fe_cnt - fe0), 32'd1);
        chk("timeout_latency_ok", 32'((dt >= TO) && (dt <= TO + 5)), 32'd1);
        chk("timeout_writes", 32'(wr_cnt - wc0), 32'd0);
        frame(8'h5A, 1'b0, HALF);

        // Enable dropped mid-frame: silent abort.
        fe0 = fe_cnt; wc0 = wr_cnt;
        send_bits(8'h99, 4, HALF);
        enable = 1'b0;
        idle(6);
        enable = 1'b1;
        idle(20);
        chk("enable_abort_err", 32'(fe_cnt - fe0), 32'd0);
        chk("enable_abort_wr", 32'(wr_cnt - wc0), 32'd0);
        frame(8'h33, 1'b0, HALF);

        // Reset mid-frame clears everything asynchronously, including sticky overrun.
        send_bits(8'hC3, 4, HALF);
        rst = 1'b0;
        #1;
        chk("midrst_write",     32'(bus.write),     32'd0);
        chk("midrst_sample",    32'(bus.sample),    32'd0);
        chk("midrst_overrun",   32'(bus.overrun),   32'd0);
        chk("midrst_frame_err", 32'(bus.frame_err), 32'd0);
        exp_ovr = 1'b0;
        last_wr = '0;
        idle(3);
        rst = 1'b1;
        idle(4);
        frame(8'hC3, 1'b0, HALF);

        for (int i = 0; i < 30; i++) begin
            rw = W'($urandom);
            rf = ($urandom_range(0, 3) == 0);
            wc0 = wr_cnt; fe0 = fe_cnt;
            frame(rw, rf, $urandom_range(3, 6));
            chk("rnd_writes", 32'(wr_cnt - wc0), 32'(!rf));
            chk("rnd_frame_err", 32'(fe_cnt - fe0), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
